time_field_decoder: RTL and testbench

Sequential decoder that splits a free-running binary seconds count into day, hour, minute and second fields for the display path. It sits downstream of the binary seconds counter, which holds the inverse packing (seconds + 60·min + 3600·hr + 86400·day). Conversion is a start/done transaction using a fixed-latency, shift-subtract long division by 86400, then 3600, then 60.

---
 rtl/time_field_decoder.sv | 177 +++++++++++++++++
 tb/tb_time_field_decoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/time_field_decoder.sv
// Splits a binary seconds count into day/hour/minute/second fields using three
// sequential shift-subtract divisions. Optional macro TIME_DECODER_BCD_EN packs
// hours, minutes and seconds as two-digit BCD.
module time_field_decoder #(
  parameter int T_WIDTH   = 28,
  parameter int DAY_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [T_WIDTH-1:0]   t,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [DAY_WIDTH-1:0] days,
  output logic [7:0]           hours,
  output logic [7:0]           minutes,
  output logic [7:0]           seconds
);

  localparam int CW = $clog2(T_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(T_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, DIV_DAY, DIV_HOUR, DIV_MIN, FINISH} state_t;

  state_t               state_q, state_d;
  logic [T_WIDTH-1:0]   div_q, div_d;
  logic [T_WIDTH-1:0]   quo_q, quo_d;
  logic [17:0]          rem_q, rem_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DAY_WIDTH-1:0] day_quo_q, day_quo_d;
  logic [7:0]           hour_quo_q, hour_quo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [DAY_WIDTH-1:0] days_q, days_d;
  logic [7:0]           hours_q, hours_d;
  logic [7:0]           minutes_q, minutes_d;
  logic [7:0]           seconds_q, seconds_d;

  logic [18:0]          divisor;
  logic [18:0]          shifted;
  logic                 fits;
  logic [17:0]          it_rem;
  logic [T_WIDTH-1:0]   it_quo;

  // The quotient MSB only ever shifts out; no field is wide enough to need it.
  logic unused_quo_msb;
  assign unused_quo_msb = quo_q[T_WIDTH-1];

  function automatic logic [7:0] field_fmt(input logic [7:0] v);
    logic [7:0] r;
`ifdef TIME_DECODER_BCD_EN
    r[7:4] = 4'(v / 8'd10);
    r[3:0] = 4'(v % 8'd10);
`else
    r = v;
`endif
    return r;
  endfunction

  // One restoring-division step against the divisor of the current stage.
  always_comb begin
    case (state_q)
      DIV_DAY:  divisor = 19'd86400;
      DIV_HOUR: divisor = 19'd3600;
      default:  divisor = 19'd60;
    endcase
    shifted = {rem_q, div_q[T_WIDTH-1]};
    fits    = (shifted >= divisor);
    it_rem  = fits ? 18'(shifted - divisor) : shifted[17:0];
    it_quo  = {quo_q[T_WIDTH-2:0], fits};
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    day_quo_d  = day_quo_q;
    hour_quo_d = hour_quo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    days_d     = days_q;
    hours_d    = hours_q;
    minutes_d  = minutes_q;
    seconds_d  = seconds_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DIV_DAY;
          busy_d  = 1'b1;
          div_d   = t;
          quo_d   = '0;
          rem_d   = '0;
          cnt_d   = LAST;
        end
      end
      DIV_DAY, DIV_HOUR, DIV_MIN: begin
        rem_d = it_rem;
        quo_d = it_quo;
        div_d = {div_q[T_WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          cnt_d = LAST;
          // Stage remainder becomes the next stage's dividend.
          if (state_q != DIV_MIN) begin
            div_d = T_WIDTH'(it_rem);
            quo_d = '0;
            rem_d = '0;
          end
          case (state_q)
            DIV_DAY: begin
              day_quo_d = it_quo[DAY_WIDTH-1:0];
              state_d   = DIV_HOUR;
            end
            DIV_HOUR: begin
              hour_quo_d = it_quo[7:0];
              state_d    = DIV_MIN;
            end
            default: state_d = FINISH;
          endcase
        end
      end
      FINISH: begin
        days_d    = day_quo_q;
        hours_d   = field_fmt(hour_quo_q);
        minutes_d = field_fmt(quo_q[7:0]);
        seconds_d = field_fmt(rem_q[7:0]);
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      day_quo_q  <= '0;
      hour_quo_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      days_q     <= '0;
      hours_q    <= '0;
      minutes_q  <= '0;
      seconds_q  <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      day_quo_q  <= day_quo_d;
      hour_quo_q <= hour_quo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      days_q     <= days_d;
      hours_q    <= hours_d;
      minutes_q  <= minutes_d;
      seconds_q  <= seconds_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign days    = days_q;
  assign hours   = hours_q;
  assign minutes = minutes_q;
  assign seconds = seconds_q;

endmodule

// File: tb/tb_time_field_decoder.sv
// Bench for time_field_decoder: arithmetic reference model checked every cycle,
// plus directed conversions with hand-computed field values.
module tb_time_field_decoder;

  localparam int T_WIDTH   = 28;
  localparam int DAY_WIDTH = 12;
  localparam int LAT       = 3 * T_WIDTH + 1;

`ifdef TIME_DECODER_BCD_EN
  localparam logic [7:0] MAX_H = 8'h21, MAX_M = 8'h24, MAX_S = 8'h15, SEC_59 = 8'h59;
`else
  localparam logic [7:0] MAX_H = 8'd21, MAX_M = 8'd24, MAX_S = 8'd15, SEC_59 = 8'd59;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [T_WIDTH-1:0]   t;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [DAY_WIDTH-1:0] days;
  logic [7:0]           hours, minutes, seconds;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  logic check_en = 1'b0;

  time_field_decoder #(.T_WIDTH(T_WIDTH), .DAY_WIDTH(DAY_WIDTH)) dut (
    .clk(clk), .reset(reset), .t(t), .start(start), .busy(busy), .done(done),
    .days(days), .hours(hours), .minutes(minutes), .seconds(seconds)
  );

  always #5 clk = ~clk;

  // Reference: fields are plain div/mod of the accepted t, ready LAT edges later.
  logic                 m_busy, m_done;
  int unsigned          m_t;
  int                   m_count;
  logic [DAY_WIDTH-1:0] m_days;
  logic [7:0]           m_hours, m_minutes, m_seconds;

  function automatic logic [7:0] fmt(input int unsigned v);
`ifdef TIME_DECODER_BCD_EN
    return 8'(((v / 10) << 4) | (v % 10));
`else
    return 8'(v);
`endif
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_count <= 0; m_t <= 0;
      m_days <= '0; m_hours <= '0; m_minutes <= '0; m_seconds <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_count == LAT - 1) begin
          m_busy    <= 1'b0;
          m_done    <= 1'b1;
          m_days    <= DAY_WIDTH'(m_t / 86400);
          m_hours   <= fmt((m_t % 86400) / 3600);
          m_minutes <= fmt((m_t % 3600) / 60);
          m_seconds <= fmt(m_t % 60);
        end
        m_count <= m_count + 1;
      end else if (start) begin
        m_busy  <= 1'b1;
        m_count <= 0;
        m_t     <= int'(t);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("cmp_busy", 32'(busy), 32'(m_busy));
      checkOutput("cmp_done", 32'(done), 32'(m_done));
      checkOutput("cmp_days", 32'(days), 32'(m_days));
      checkOutput("cmp_hours", 32'(hours), 32'(m_hours));
      checkOutput("cmp_minutes", 32'(minutes), 32'(m_minutes));
      checkOutput("cmp_seconds", 32'(seconds), 32'(m_seconds));
    end
    if (done === 1'b1) done_count++;
  end

  // Presents t with start for one edge; returns at the negedge after that edge.
  task automatic applyStimulus(input logic [T_WIDTH-1:0] tv);
    @(negedge clk);
    t = tv;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int start_cyc, output int done_cyc);
    int c;
    c = start_cyc;
    done_cyc = -1;
    while (c < start_cyc + 200 && done_cyc < 0) begin
      @(negedge clk);
      c++;
      if (done === 1'b1) done_cyc = c;
    end
    if (done_cyc < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no done, want done within 200 cycles");
    end
  endtask

  task automatic checkFields(input string tag, input logic [31:0] d, input logic [7:0] h,
                             input logic [7:0] m, input logic [7:0] s);
    checkOutput({tag, "_days"}, 32'(days), d);
    checkOutput({tag, "_hours"}, 32'(hours), 32'(h));
    checkOutput({tag, "_minutes"}, 32'(minutes), 32'(m));
    checkOutput({tag, "_seconds"}, 32'(seconds), 32'(s));
  endtask

  initial begin
    int dc;
    int dcount0;
    reset = 1'b1;
    start = 1'b0;
    t     = '0;
    repeat (3) @(posedge clk);
    check_en = 1'b1;
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkFields("rst", 32'd0, 8'd0, 8'd0, 8'd0);
    reset = 1'b0;

    $display("[TB] zero input");
    applyStimulus('0);
    waitDone(0, dc);
    checkOutput("zero_latency", 32'(dc), 32'd85);
    checkOutput("zero_busy_at_done", 32'(busy), 32'd0);
    checkFields("zero", 32'd0, 8'd0, 8'd0, 8'd0);
    @(negedge clk);
    checkOutput("zero_done_one_cycle", 32'(done), 32'd0);

    $display("[TB] unit fields");
    applyStimulus(28'd90061);
    waitDone(0, dc);
    checkOutput("unit_latency", 32'(dc), 32'd85);
    checkFields("unit", 32'd1, 8'h01, 8'h01, 8'h01);

    $display("[TB] reset while idle");
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("idle_rst_busy", 32'(busy), 32'd0);
    checkFields("idle_rst", 32'd0, 8'd0, 8'd0, 8'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] maximum input");
    applyStimulus(28'd268435455);
    waitDone(0, dc);
    checkOutput("max_latency", 32'(dc), 32'd85);
    checkFields("max", 32'd3106, MAX_H, MAX_M, MAX_S);

    $display("[TB] inputs ignored while busy");
    applyStimulus(28'd3661);
    dcount0 = done_count;
    repeat (9) @(negedge clk);
    t = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(10, dc);
    checkOutput("busy_ign_latency", 32'(dc), 32'd85);
    checkFields("busy_ign", 32'd0, 8'h01, 8'h01, 8'h01);
    repeat (100) @(negedge clk);
    checkOutput("busy_ign_single_done", 32'(done_count - dcount0), 32'd1);

    $display("[TB] start held across busy-falling edge");
    applyStimulus(28'd120);
    repeat (84) @(negedge clk);
    t = 28'd7;
    start = 1'b1;
    @(negedge clk);
    checkOutput("b2b_first_done", 32'(done), 32'd1);
    checkFields("b2b_first", 32'd0, 8'd0, 8'h02, 8'h00);
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b_accepted", 32'(busy), 32'd1);
    waitDone(0, dc);
    checkOutput("b2b_latency", 32'(dc), 32'd85);
    checkFields("b2b_second", 32'd0, 8'd0, 8'd0, 8'h07);

    $display("[TB] reset mid-conversion");
    applyStimulus(28'd90061);
    repeat (39) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkFields("mid_rst", 32'd0, 8'd0, 8'd0, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    dcount0 = done_count;
    repeat (100) @(negedge clk);
    checkOutput("mid_rst_no_done", 32'(done_count - dcount0), 32'd0);
    applyStimulus(28'd59);
    waitDone(0, dc);
    checkOutput("after_rst_latency", 32'(dc), 32'd85);
    checkFields("after_rst", 32'd0, 8'd0, 8'd0, SEC_59);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
